// File: rtl/onehot_demux_pkg.sv
// Shared types and helpers for the one-hot steered demultiplexer.
package onehot_demux_pkg;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

  // Widest select vector the one-hot check supports; narrower selects are zero-extended.
  localparam int unsigned ONEHOT_MAX_W = 64;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot_lsb();
    logic [ONEHOT_MAX_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - onehot_lsb())) == '0);
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel of onehot_demux_buffer: a single-entry register slot with EMPTY/FULL state.
module demux_out_slot
  import onehot_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  free
);

  slot_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (wr) state <= SLOT_FULL;
        SLOT_FULL:  if (out_ready && !wr) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      if (wr) out_data <= wdata;
    end
  end

  assign out_valid = (state == SLOT_FULL);
  // A draining slot can accept a new beat in the same cycle.
  assign free      = (state == SLOT_EMPTY) || out_ready;

endmodule

// File: rtl/onehot_demux_buffer.sv
// One-hot steered demultiplexer with a 1-entry register slot per output channel.
// Optional illegal-select checking and error counting enabled by defining ONEHOT_CHECK_EN.
module onehot_demux_buffer
  import onehot_demux_pkg::*;
#(
  parameter int unsigned OUTPUTS    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [OUTPUTS-1:0]            sel,
  output logic [OUTPUTS-1:0]            out_valid,
  input  logic [OUTPUTS-1:0]            out_ready,
  output logic [OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic                          err_sticky,
  output logic [CNT_WIDTH-1:0]          err_cnt
);

  logic [OUTPUTS-1:0] free;
  logic [OUTPUTS-1:0] wr;
  logic               all_sel_free;

  assign all_sel_free = &(~sel | free);

`ifdef ONEHOT_CHECK_EN
  logic [ONEHOT_MAX_W-1:0] sel_ext;
  logic                    sel_legal;

  always_comb begin
    sel_ext              = '0;
    sel_ext[OUTPUTS-1:0] = sel;
  end

  assign sel_legal = is_onehot(sel_ext);
  // Illegal beats are always accepted so they can be dropped without stalling the producer.
  assign in_ready  = !sel_legal || all_sel_free;
  assign wr        = {OUTPUTS{in_valid && in_ready && sel_legal}} & sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (in_valid && !sel_legal) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign in_ready   = all_sel_free;
  assign wr         = {OUTPUTS{in_valid && in_ready}} & sel;
  assign err_sticky = 1'b0;
  assign err_cnt    = '0;
`endif

  for (genvar i = 0; i < OUTPUTS; i++) begin : g_slot
    demux_out_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr[i]),
      .wdata    (in_data),
      .out_ready(out_ready[i]),
      .out_valid(out_valid[i]),
      .out_data (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .free     (free[i])
    );
  end

endmodule

// File: tb/tb_onehot_demux_buffer.sv
// Scoreboard bench for onehot_demux_buffer; illegal-select cases follow ONEHOT_CHECK_EN.
module tb_onehot_demux_buffer;
  localparam int unsigned OUTPUTS = 4;
  localparam int unsigned DW      = 16;
  localparam int unsigned CW      = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic [OUTPUTS-1:0]    sel;
  logic [OUTPUTS-1:0]    out_valid;
  logic [OUTPUTS-1:0]    out_ready;
  logic [OUTPUTS*DW-1:0] out_data;
  logic                  err_sticky;
  logic [CW-1:0]         err_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] expq[OUTPUTS][$];

  always #5 clk = ~clk;

  onehot_demux_buffer #(
    .OUTPUTS   (OUTPUTS),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt)
  );

  function automatic logic [DW-1:0] ch(input int unsigned i);
    return out_data[i*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    sel      = '0;
    in_data  = '0;
  endtask

  // Drive one beat; returns once it is accepted (at posedge+1), leaving in_valid asserted.
  task automatic send(input logic [OUTPUTS-1:0] s, input logic [DW-1:0] d, output int waited);
    logic legal;
    in_valid = 1'b1;
    sel      = s;
    in_data  = d;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: sel %0h never accepted", s);
        break;
      end
    end
`ifdef ONEHOT_CHECK_EN
    legal = ($countones(s) == 1);
`else
    legal = 1'b1;
`endif
    if (legal && in_ready)
      for (int unsigned i = 0; i < OUTPUTS; i++)
        if (s[i]) expq[i].push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n;
    rst_n     = 1'b1;
    out_ready = '0;
    idle();

    fork
      forever begin
        @(negedge clk);
        if (rst_n)
          for (int unsigned i = 0; i < OUTPUTS; i++)
            if (out_valid[i] && out_ready[i]) begin
              if (expq[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat ch%0d: got %0h expected none", i, ch(i));
              end else begin
                chk($sformatf("out_data_ch%0d", i), 64'(ch(i)), 64'(expq[i].pop_front()));
              end
            end
      end
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_err_sticky", 64'(err_sticky), 64'd0);
    chk("reset_err_cnt", 64'(err_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Steering
    out_ready = '1;
    send(4'b0100, 16'hBEEF, w);
    idle();
    @(negedge clk);
    chk("steer_out_valid", 64'(out_valid), 64'b0100);
    chk("steer_ch0", 64'(ch(0)), 64'd0);
    chk("steer_ch1", 64'(ch(1)), 64'd0);
    chk("steer_ch3", 64'(ch(3)), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure
    out_ready = '0;
    send(4'b0010, 16'h1111, w);
    sel     = 4'b0010;
    in_data = 16'h2222;
    @(negedge clk);
    chk("bp_in_ready_a", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp_in_ready_b", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'b0010);
    chk("bp_hold_ch1", 64'(ch(1)), 64'h1111);
    @(posedge clk);
    #1;
    send(4'b1000, 16'h3333, w);
    chk("bp_other_ready", 64'(w), 64'd0);
    idle();
    @(negedge clk);
    chk("bp_out_valid2", 64'(out_valid), 64'b1010);
    chk("bp_ch1_untouched", 64'(ch(1)), 64'h1111);
    chk("bp_ch3", 64'(ch(3)), 64'h3333);
    @(posedge clk);
    #1 out_ready = '1;
    @(posedge clk);
    #1;

    // Streaming
    for (int k = 0; k < 8; k++) begin
      send(4'b0001, DW'(k), w);
      chk($sformatf("stream_ready_%0d", k), 64'(w), 64'd0);
      chk($sformatf("stream_valid_%0d", k), 64'(out_valid[0]), 64'd1);
      chk($sformatf("stream_data_%0d", k), 64'(ch(0)), 64'(k));
    end
    idle();
    @(posedge clk);
    #1;
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset with slot 2 FULL
    out_ready = '0;
    send(4'b0100, 16'h5555, w);
    idle();
    @(negedge clk);
    chk("rst_pre_valid", 64'(out_valid), 64'b0100);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_data", out_data, 64'd0);
    for (int unsigned i = 0; i < OUTPUTS; i++) expq[i].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_post_valid", 64'(out_valid), 64'd0);

    // Illegal selects
`ifdef ONEHOT_CHECK_EN
    send(4'b0110, 16'h1234, w);
    chk("ill_multi_ready", 64'(w), 64'd0);
    send(4'b0000, 16'h5678, w);
    chk("ill_zero_ready", 64'(w), 64'd0);
    idle();
    @(negedge clk);
    chk("ill_out_valid", 64'(out_valid), 64'd0);
    chk("ill_err_sticky", 64'(err_sticky), 64'd1);
    chk("ill_err_cnt", 64'(err_cnt), 64'd2);
    @(posedge clk);
    #1;
`else
    send(4'b0110, 16'h1234, w);
    idle();
    @(negedge clk);
    chk("bcast_out_valid", 64'(out_valid), 64'b0110);
    chk("bcast_ch1", 64'(ch(1)), 64'h1234);
    chk("bcast_ch2", 64'(ch(2)), 64'h1234);
    chk("bcast_err_sticky", 64'(err_sticky), 64'd0);
    chk("bcast_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1 out_ready = '1;
    @(posedge clk);
    #1;
    send(4'b0000, 16'h5678, w);
    chk("zero_sel_ready", 64'(w), 64'd0);
    idle();
    @(negedge clk);
    chk("zero_sel_out_valid", 64'(out_valid), 64'd0);
    chk("zero_sel_err_cnt", 64'(err_cnt), 64'd0);
`endif

    // Drain and confirm every expected beat appeared
    out_ready = '1;
    n = 0;
    while (n < 50 && (expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0) begin
      @(posedge clk);
      n++;
    end
    #1;
    for (int unsigned i = 0; i < OUTPUTS; i++)
      chk($sformatf("leftover_ch%0d", i), 64'(expq[i].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
